hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_if.sv | 29 ++
 rtl/hazard_unit.sv | 83 ++++++++
 tb/tb_hazard_unit.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// Hazard unit <-> datapath bundle: per-stage indices and control in, forward/stall/flush and counters out.
// Pure wiring; no latency, no backpressure.
interface hazard_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
);
  logic [REG_ADDR_WIDTH-1:0] Rs1D_i, Rs2D_i, RdD_i;
  logic                      RegWriteD_i;
  logic [1:0]                ResultSrcD_i;
  logic [REG_ADDR_WIDTH-1:0] Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i;
  logic                      PCSrcE_i;
  logic [1:0]                FowardAE_o, FowardBE_o;
  logic                      StallF_o, StallD_o, FlushD_o, Drst_o;
  logic [CNT_WIDTH-1:0]      stall_count_o, flush_count_o;

  modport master (
    output Rs1D_i, Rs2D_i, RdD_i, RegWriteD_i, ResultSrcD_i,
           Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i, PCSrcE_i,
    input  FowardAE_o, FowardBE_o, StallF_o, StallD_o, FlushD_o, Drst_o,
           stall_count_o, flush_count_o
  );

  modport slave (
    input  Rs1D_i, Rs2D_i, RdD_i, RegWriteD_i, ResultSrcD_i,
           Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i, PCSrcE_i,
    output FowardAE_o, FowardBE_o, StallF_o, StallD_o, FlushD_o, Drst_o,
           stall_count_o, flush_count_o
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding selects, load-use stall, branch flush, saturating event counters.
// Latency: outputs combinational (zero cycles); backpressure: asserts StallF/StallD on load-use, branch overrides.
module hazard_unit #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic     clk,
  input  logic     rst_n_i,
  hazard_if.slave  hz
);
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
  } ctrl_t;

  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  ctrl_t                ctrl_e_q, ctrl_m_q, ctrl_w_q, ctrl_e_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic                 lw_stall, stall_evt;
  logic [1:0]           fwd_a, fwd_b;

  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    // M takes priority over W so the youngest producer wins
    if (ctrl_m_q.reg_write && hz.RdM_i != '0 && hz.RdM_i == hz.Rs1E_i)
      fwd_a = FWD_MEM;
    else if (ctrl_w_q.reg_write && hz.RdW_i != '0 && hz.RdW_i == hz.Rs1E_i)
      fwd_a = FWD_WB;
    if (ctrl_m_q.reg_write && hz.RdM_i != '0 && hz.RdM_i == hz.Rs2E_i)
      fwd_b = FWD_MEM;
    else if (ctrl_w_q.reg_write && hz.RdW_i != '0 && hz.RdW_i == hz.Rs2E_i)
      fwd_b = FWD_WB;

    lw_stall = (ctrl_e_q.result_src == RES_LOAD) && ctrl_e_q.reg_write &&
               (hz.RdE_i != '0) &&
               ((hz.Rs1D_i == hz.RdE_i) || (hz.Rs2D_i == hz.RdE_i));
    stall_evt = lw_stall && !hz.PCSrcE_i;

    hz.FowardAE_o = fwd_a;
    hz.FowardBE_o = fwd_b;
    hz.StallF_o   = stall_evt;
    hz.StallD_o   = stall_evt;
    hz.FlushD_o   = hz.PCSrcE_i;
    hz.Drst_o     = stall_evt || hz.PCSrcE_i;

    ctrl_e_d = hz.Drst_o ? ctrl_t'('0)
                         : ctrl_t'{reg_write: hz.RegWriteD_i, result_src: hz.ResultSrcD_i};

    stall_cnt_d = stall_cnt_q;
    if (stall_evt && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 1'b1;
    flush_cnt_d = flush_cnt_q;
    if (hz.PCSrcE_i && flush_cnt_q != '1)
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ctrl_e_q    <= '0;
      ctrl_m_q    <= '0;
      ctrl_w_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ctrl_e_q    <= ctrl_e_d;
      ctrl_m_q    <= ctrl_e_q;
      ctrl_w_q    <= ctrl_m_q;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_count_o = stall_cnt_q;
  assign hz.flush_count_o = flush_cnt_q;

  logic unused_rd_d;
  assign unused_rd_d = ^hz.RdD_i;
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: forwarding priority, load-use stall, branch override, saturation, async reset.
// Counter width is narrowed so saturation is reached in a few hundred cycles.
module tb_hazard_unit;
  localparam int CW = 8;
  localparam logic [31:0] CMAX = (32'd1 << CW) - 32'd1;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  hazard_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(CW)) hif ();

  hazard_unit #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(CW)) dut (
    .clk     (clk),
    .rst_n_i (rst_n),
    .hz      (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hif.Rs1D_i = '0; hif.Rs2D_i = '0; hif.RdD_i = '0;
    hif.RegWriteD_i = 1'b0; hif.ResultSrcD_i = 2'b00;
    hif.Rs1E_i = '0; hif.Rs2E_i = '0; hif.RdE_i = '0;
    hif.RdM_i = '0; hif.RdW_i = '0; hif.PCSrcE_i = 1'b0;
  endtask

  task automatic drain();
    hif.RegWriteD_i = 1'b0; hif.ResultSrcD_i = 2'b00;
    repeat (3) tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    clear_inputs();
    #3;
    chk("rst_fwdA", 32'(hif.FowardAE_o), 32'd0);
    chk("rst_fwdB", 32'(hif.FowardBE_o), 32'd0);
    chk("rst_stallF", 32'(hif.StallF_o), 32'd0);
    chk("rst_stallD", 32'(hif.StallD_o), 32'd0);
    chk("rst_drst", 32'(hif.Drst_o), 32'd0);
    chk("rst_scnt", 32'(hif.stall_count_o), 32'd0);
    chk("rst_fcnt", 32'(hif.flush_count_o), 32'd0);
    hif.PCSrcE_i = 1'b1;
    #1;
    chk("rst_drst_follows_pcsrc", 32'(hif.Drst_o), 32'd1);
    hif.PCSrcE_i = 1'b0;
    #3 rst_n = 1'b1;
    tick();

    // ALU writer of x5, reader one then two cycles later
    hif.RegWriteD_i = 1'b1; hif.ResultSrcD_i = 2'b00; hif.RdD_i = 5'd5;
    tick();
    hif.RegWriteD_i = 1'b0; hif.RdD_i = 5'd0;
    tick();
    hif.Rs1E_i = 5'd5; hif.RdM_i = 5'd5;
    #1;
    chk("fwdA_mem", 32'(hif.FowardAE_o), 32'd2);
    chk("fwdB_none", 32'(hif.FowardBE_o), 32'd0);
    tick();
    hif.RdM_i = 5'd0; hif.RdW_i = 5'd5;
    #1;
    chk("fwdA_wb", 32'(hif.FowardAE_o), 32'd1);

    // Writers of x7 in both M and W
    clear_inputs();
    drain();
    hif.RegWriteD_i = 1'b1;
    repeat (3) tick();
    hif.RdM_i = 5'd7; hif.RdW_i = 5'd7; hif.Rs2E_i = 5'd7;
    #1;
    chk("fwdB_mem_over_wb", 32'(hif.FowardBE_o), 32'd2);
    hif.RdM_i = 5'd0; hif.Rs1E_i = 5'd0;
    #1;
    chk("fwdA_x0", 32'(hif.FowardAE_o), 32'd0);
    chk("fwdB_wb_when_rdm0", 32'(hif.FowardBE_o), 32'd1);

    // Load to x3 followed by a consumer of x3
    clear_inputs();
    drain();
    hif.RegWriteD_i = 1'b1; hif.ResultSrcD_i = 2'b01; hif.RdD_i = 5'd3;
    tick();
    hif.RegWriteD_i = 1'b0; hif.ResultSrcD_i = 2'b00; hif.RdD_i = 5'd0;
    hif.RdE_i = 5'd3; hif.Rs1D_i = 5'd3;
    #1;
    chk("lu_stallF", 32'(hif.StallF_o), 32'd1);
    chk("lu_stallD", 32'(hif.StallD_o), 32'd1);
    chk("lu_drst", 32'(hif.Drst_o), 32'd1);
    chk("lu_flushD", 32'(hif.FlushD_o), 32'd0);
    chk("lu_scnt_before", 32'(hif.stall_count_o), 32'd0);
    tick();
    hif.RdE_i = 5'd0;
    #1;
    chk("lu_scnt_after", 32'(hif.stall_count_o), 32'd1);
    chk("lu_bubble_no_stall", 32'(hif.StallF_o), 32'd0);
    tick();
    hif.Rs1D_i = 5'd0; hif.Rs1E_i = 5'd3; hif.RdW_i = 5'd3; hif.RdM_i = 5'd0;
    #1;
    chk("lu_consumer_fwdA", 32'(hif.FowardAE_o), 32'd1);

    // Load-use coincident with a taken branch
    clear_inputs();
    drain();
    hif.RegWriteD_i = 1'b1; hif.ResultSrcD_i = 2'b01; hif.RdD_i = 5'd3;
    tick();
    hif.RegWriteD_i = 1'b0; hif.ResultSrcD_i = 2'b00;
    hif.RdE_i = 5'd3; hif.Rs1D_i = 5'd3; hif.PCSrcE_i = 1'b1;
    #1;
    chk("br_flushD", 32'(hif.FlushD_o), 32'd1);
    chk("br_drst", 32'(hif.Drst_o), 32'd1);
    chk("br_stallF", 32'(hif.StallF_o), 32'd0);
    chk("br_stallD", 32'(hif.StallD_o), 32'd0);
    tick();
    hif.PCSrcE_i = 1'b0;
    #1;
    chk("br_fcnt", 32'(hif.flush_count_o), 32'd1);
    chk("br_scnt_unchanged", 32'(hif.stall_count_o), 32'd1);

    // Asynchronous reset in the middle of a stall
    clear_inputs();
    drain();
    hif.RegWriteD_i = 1'b1; hif.ResultSrcD_i = 2'b01; hif.RdD_i = 5'd3;
    tick();
    hif.RdE_i = 5'd3; hif.Rs1D_i = 5'd3;
    #1;
    chk("mid_stall_active", 32'(hif.StallF_o), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_stallF", 32'(hif.StallF_o), 32'd0);
    chk("mid_rst_stallD", 32'(hif.StallD_o), 32'd0);
    chk("mid_rst_drst", 32'(hif.Drst_o), 32'd0);
    chk("mid_rst_scnt", 32'(hif.stall_count_o), 32'd0);
    chk("mid_rst_fcnt", 32'(hif.flush_count_o), 32'd0);
    tick();
    chk("rst_edge_no_incr", 32'(hif.stall_count_o), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_shift", 32'(hif.StallF_o), 32'd1);

    // Alternating load/bubble in E: one stall every two cycles up to saturation
    for (int i = 0; i < int'(CMAX); i++) begin
      tick();
      tick();
    end
    chk("sat_reach_max", 32'(hif.stall_count_o), CMAX);
    chk("sat_stall_active", 32'(hif.StallF_o), 32'd1);
    tick();
    chk("sat_hold_max", 32'(hif.stall_count_o), CMAX);
    chk("sat_fcnt_zero", 32'(hif.flush_count_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
